// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared fetch constants, fetch FSM encoding and address-range helper
package cpu_defs;
    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam logic [29:0] MEM_LO_WORD = 30'h0010_0000;
    localparam logic [29:0] MEM_HI_WORD = 30'h0010_0023;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    function automatic logic word_in_range(
        input logic [29:0] w,
        input logic [29:0] lo,
        input logic [29:0] hi
    );
        return (w >= lo) && (w <= hi);
    endfunction
endpackage

// File: rtl/inst_fetch_ctrl_fetch_buf.sv
// fetch_buf: 2-entry {pc, inst} FIFO with push/pop/flush; flush wins over push and pop
//   clk, rst_n          : clock, synchronous active-low reset (empties the buffer)
//   push/push_pc/_inst  : enqueue an entry (only while not full, or together with pop)
//   pop                 : dequeue the head (only while not empty)
//   flush               : discard all entries
//   count, head_pc/_inst: occupancy and head entry (don't-care when count==0)
module fetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    output logic [1:0]  count,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst
);
    logic [1:0]  count_q, count_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic        tail;

    assign count     = count_q;
    assign head_pc   = pc0_q;
    assign head_inst = inst0_q;
    // New entry lands in slot 1 if an entry still sits in slot 0 after this cycle's pop
    assign tail      = (count_q == 2'd2) || (count_q == 2'd1 && !pop);

    always_comb begin
        pc0_d   = pop ? pc1_q : pc0_q;
        inst0_d = pop ? inst1_q : inst0_q;
        pc1_d   = pc1_q;
        inst1_d = inst1_q;
        if (push && !tail) begin
            pc0_d   = push_pc;
            inst0_d = push_inst;
        end
        if (push && tail) begin
            pc1_d   = push_pc;
            inst1_d = push_inst;
        end
        count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        count_q <= !rst_n ? 2'd0 : count_d;
        pc0_q   <= pc0_d;
        pc1_q   <= pc1_d;
        inst0_q <= inst0_d;
        inst1_q <= inst1_d;
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: sequential instruction fetch into a 2-entry buffer with redirect and range fault
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_addr / imem_data      : word address to instruction memory, combinational read data
//   redirect_valid/redirect_pc : flush and restart fetch at a new byte address
//   inst_valid/inst/inst_pc    : buffer head to decode; inst_ready completes the handshake
//   fault                      : registered, high while fetch is stopped on a bad address
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = cpu_defs::RESET_PC,
    parameter logic [29:0] MEM_LO_WORD = cpu_defs::MEM_LO_WORD,
    parameter logic [29:0] MEM_HI_WORD = cpu_defs::MEM_HI_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault
);
    cpu_defs::fetch_state_e state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  count;
    logic        handshake, pc_ok, tgt_ok, fetch;

    assign imem_addr  = fetch_pc_q[31:2];
    assign fault      = fault_q;
    assign inst_valid = count != 2'd0;
    assign handshake  = inst_valid && inst_ready;
    assign pc_ok      = cpu_defs::word_in_range(fetch_pc_q[31:2], MEM_LO_WORD, MEM_HI_WORD);
    assign tgt_ok     = redirect_pc[1:0] == 2'b00 &&
                        cpu_defs::word_in_range(redirect_pc[31:2], MEM_LO_WORD, MEM_HI_WORD);
    // A full buffer may still take a fetch when decode drains the head in the same cycle
    assign fetch      = state_q == cpu_defs::ST_RUN && !redirect_valid && pc_ok &&
                        (count != 2'd2 || handshake);

    always_comb begin
        fetch_pc_d = redirect_valid ? redirect_pc : fetch ? fetch_pc_q + 32'd4 : fetch_pc_q;
        state_d    = redirect_valid ? (tgt_ok ? cpu_defs::ST_RUN : cpu_defs::ST_FAULT) :
                     (state_q == cpu_defs::ST_RUN && !pc_ok) ? cpu_defs::ST_FAULT : state_q;
        fault_d    = state_d == cpu_defs::ST_FAULT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            state_q    <= cpu_defs::ST_RUN;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
            fault_q    <= fault_d;
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch),
        .pop       (handshake),
        .flush     (redirect_valid),
        .push_pc   (fetch_pc_q),
        .push_inst (imem_data),
        .count     (count),
        .head_pc   (inst_pc),
        .head_inst (inst)
    );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed stimulus with an expected-PC queue checked by a handshake monitor
module tb_inst_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic [29:0] imem_addr;
    logic [31:0] imem_data, inst, inst_pc;
    logic        inst_valid, fault;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hC0DE_1234;
    endfunction

    assign imem_data = mem_word(imem_addr);

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fault          (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && !redirect_valid && inst_valid && inst_ready) begin
            logic [31:0] e;
            n_acc++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_handshake: got pc %h expected none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst", inst, mem_word(e[31:2]));
                last_pc = inst_pc;
            end
        end
    end

    initial begin
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0010_0000);

        tick();
        load(32'h0040_0000, 16);
        n_acc = 0;
        rst_n = 1'b1;
        inst_ready = 1'b1;
        repeat (4) tick();
        inst_ready = 1'b0;
        chk("stream_accepts", 32'(n_acc), 32'd3);
        repeat (3) tick();
        @(negedge clk);
        chk("full_valid", 32'(inst_valid), 32'd1);
        chk("full_head_pc", inst_pc, 32'h0040_000C);

        tick();
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0050_0000;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_fault", 32'(fault), 32'd0);
        chk("midrst_imem_addr", 32'(imem_addr), 32'h0010_0000);

        tick();
        rst_n = 1'b1;
        load(32'h0040_0000, 8);
        n_acc = 0;
        tick();
        tick();
        @(negedge clk);
        chk("stall_imem_addr_a", 32'(imem_addr), 32'h0010_0002);
        chk("stall_pc_a", inst_pc, 32'h0040_0000);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("stall_imem_addr_b", 32'(imem_addr), 32'h0010_0002);
        chk("stall_pc_b", inst_pc, 32'h0040_0000);
        chk("stall_valid", 32'(inst_valid), 32'd1);
        tick();
        inst_ready = 1'b1;
        repeat (6) tick();
        inst_ready = 1'b0;
        chk("drain_accepts", 32'(n_acc), 32'd6);
        repeat (2) tick();

        load(32'h0040_0040, 20);
        redirect(32'h0040_0040);
        @(negedge clk);
        chk("redir_valid_gap", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk("redir_pc", inst_pc, 32'h0040_0040);
        chk("redir_inst", inst, mem_word(30'h0010_0010));

        tick();
        n_acc = 0;
        inst_ready = 1'b1;
        for (int i = 0; i < 100 && !fault; i++) tick();
        chk("end_fault", 32'(fault), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("end_valid", 32'(inst_valid), 32'd0);
        chk("end_imem_addr", 32'(imem_addr), 32'h0010_0024);
        chk("end_last_pc", last_pc, 32'h0040_008C);
        chk("end_accepts", 32'(n_acc), 32'd20);
        chk("end_queue_left", 32'(exp_q.size()), 32'd0);

        tick();
        inst_ready = 1'b0;
        load(32'h0040_0010, 4);
        redirect(32'h0040_0010);
        @(negedge clk);
        chk("recover_fault", 32'(fault), 32'd0);
        tick();
        redirect(32'h0040_0002);
        @(negedge clk);
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_valid", 32'(inst_valid), 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("misalign_hold_addr", 32'(imem_addr), 32'h0010_0000);
        chk("misalign_hold_fault", 32'(fault), 32'd1);
        chk("misalign_no_fetch", 32'(inst_valid), 32'd0);
        tick();
        redirect(32'h0040_0010);
        @(negedge clk);
        chk("clear_fault", 32'(fault), 32'd0);
        tick();
        @(negedge clk);
        chk("clear_valid", 32'(inst_valid), 32'd1);
        chk("clear_pc", inst_pc, 32'h0040_0010);
        tick();
        redirect(32'h0050_0000);
        @(negedge clk);
        chk("range_fault", 32'(fault), 32'd1);
        chk("range_valid", 32'(inst_valid), 32'd0);
        chk("range_imem_addr", 32'(imem_addr), 32'h0014_0000);
        tick();
        load(32'h0040_0010, 4);
        n_acc = 0;
        redirect(32'h0040_0010);
        inst_ready = 1'b1;
        repeat (4) tick();
        inst_ready = 1'b0;
        chk("final_fault", 32'(fault), 32'd0);
        chk("final_accepts", 32'(n_acc), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, byte address of the first fetch after reset.
REQ-002 Parameter: MEM_LO_WORD, 30'h0010_0000, lowest valid instruction-memory word address.
REQ-003 Parameter: MEM_HI_WORD, 30'h0010_0023, highest valid instruction-memory word address.
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port: imem_addr  output  30  word read address to the instruction memory, equal to fetch_pc[31:2].
REQ-007 Port: imem_data  input  32  combinational read data from the instruction memory for imem_addr.
REQ-008 Port: redirect_valid  input  1  branch/jump redirect request from the execute stage.
REQ-009 Port: redirect_pc  input  32  byte target address of the redirect.
REQ-010 Port: inst_valid  output  1  the buffer head holds an instruction for decode.
REQ-011 Port: inst  output  32  instruction word at the buffer head.
REQ-012 Port: inst_pc  output  32  byte PC of the instruction at the buffer head.
REQ-013 Port: inst_ready  input  1  decode accepts the head this cycle; handshake = inst_valid & inst_ready.
REQ-014 Port: fault  output  1  fetch is stopped on a misaligned or out-of-range address.

Function
REQ-015 The block SHALL hold a 32-bit fetch_pc register, a 2-entry FIFO of {pc, inst}, and a 2-state FSM: RUN, FAULT.
REQ-016 In RUN, a fetch SHALL occur when redirect_valid=0, fetch_pc is in range, and (count<2 or a handshake occurs this cycle).
REQ-017 A fetch SHALL push {fetch_pc, imem_data} into the FIFO and advance fetch_pc by 4 (32-bit wrap).
REQ-018 Latency: an instruction fetched in cycle N SHALL appear on inst/inst_pc with inst_valid=1 in cycle N+1 at the earliest.
REQ-019 inst_valid SHALL equal (count!=0); inst and inst_pc SHALL show the head entry and are don't-care when inst_valid=0.
REQ-020 A push and a pop in the same cycle while full SHALL leave count at 2 with FIFO order preserved.
REQ-021 Once inst_valid=1, the head entry SHALL be held stable until a handshake or a redirect occurs.
REQ-022 redirect_valid=1 SHALL take priority over push and pop: the FIFO is flushed (count=0), fetch_pc <= redirect_pc, and no fetch occurs that cycle.
REQ-023 A handshake coinciding with a redirect SHALL count as consumed; the entry is discarded by the flush.
REQ-024 A redirect with redirect_pc[1:0]!=0, or with redirect_pc[31:2] outside [MEM_LO_WORD, MEM_HI_WORD], SHALL flush the FIFO and move the FSM to FAULT.
REQ-025 A redirect with an aligned, in-range redirect_pc SHALL move the FSM to RUN, including from FAULT.
REQ-026 In RUN, when fetch_pc[31:2] > MEM_HI_WORD or < MEM_LO_WORD, the block SHALL not push, SHALL move to FAULT, and SHALL let already buffered entries still drain.
REQ-027 In FAULT, the block SHALL not fetch, fetch_pc SHALL hold, fault SHALL be 1, and only a valid redirect (REQ-025) or reset SHALL leave FAULT.
REQ-028 fault SHALL be a registered output, equal to 1 exactly while the FSM is in FAULT.

Reset
REQ-029 When rst_n=0 at a rising clk edge: fetch_pc <= RESET_PC, count <= 0, FSM <= RUN, fault <= 0; inst_valid SHALL then be 0.
REQ-030 Reset SHALL override redirect_valid and any handshake in the same cycle; an in-flight buffer SHALL be discarded.
REQ-031 During reset, imem_addr SHALL equal RESET_PC[31:2] from the first cycle after the reset edge.

Structure
REQ-032 RESET_PC, MEM_LO_WORD, MEM_HI_WORD and the FSM state encoding SHALL live in the shared cpu_defs package.
REQ-033 The 2-entry FIFO SHALL be a sub-module fetch_buf (push/pop/flush, count, head outputs); the PC and FSM logic SHALL stay in inst_fetch_ctrl.

Verification
REQ-034 Reset release with inst_ready=1: inst_pc SHALL read 0x00400000, 0x00400004, 0x00400008 in consecutive cycles, with inst equal to memory words 0x00100000..2.
REQ-035 inst_ready=0 for 5 cycles: count saturates at 2, inst_pc stays 0x00400000 and imem_addr stays 0x00100002; then with inst_ready=1, no instruction is lost or duplicated.
REQ-036 Redirect to 0x00400040 while full: the next cycle inst_valid=0, then inst_pc=0x00400040 and inst=word 0x00100010.
REQ-037 Sequential run to the end: the last inst_pc is 0x0040008C, then fault=1 after the buffer drains, and imem_addr holds 0x00100024.
REQ-038 Redirect to 0x00400002 or 0x00500000: fault=1 the next cycle, inst_valid=0; a later redirect to 0x00400010 clears fault and delivers inst_pc=0x00400010.
REQ-039 rst_n=0 asserted mid-stream with count=2 and redirect_valid=1: the next cycle count=0, fault=0, imem_addr=0x00100000.
